motor_drive_ctrl: RTL
=====================

MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

Interface
REQ-001 SHALL have parameter PWM_PERIOD, default 16, PWM frame length in cycles (2..255).
REQ-002 SHALL have parameter RAMP_STEP, default 4, duty increment per PWM frame in DRIVE.
REQ-003 SHALL have parameter TURN_CYCLES, default 32, spin duration in cycles (1..65535).
REQ-004 SHALL have parameter TURN_DUTY, default 8, fixed duty during spin (0..PWM_PERIOD).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port state_in  input  2  navigation state code: 00 IDLE, 01 MOVE_FORWARD, 10 TURN_LEFT, 11 TURN_RIGHT.
REQ-008 SHALL have port pwm_left, pwm_right  output  1 each  motor PWM enables.
REQ-009 SHALL have port dir_left, dir_right  output  1 each  motor direction, 1 forward, 0 reverse.
REQ-010 SHALL have port busy  output  1  high while a spin is in progress.
REQ-011 SHALL have port turn_done  output  1  one-cycle pulse on normal spin completion.

Function
REQ-012 SHALL run an internal mode FSM with states STOP, DRIVE, SPIN_L, SPIN_R, sampling state_in every cycle.
REQ-013 SHALL transition from STOP or DRIVE on state_in: 00 -> STOP, 01 -> DRIVE, 10 -> SPIN_L, 11 -> SPIN_R.
REQ-014 SHALL latch a spin once entered: state_in 01/10/11 ignored until spin completes; turn counter cleared to 0 on entry.
REQ-015 SHALL abort a spin to STOP when state_in == 00, with no turn_done pulse.
REQ-016 SHALL complete a spin when turn counter == TURN_CYCLES-1: pulse turn_done next cycle; next mode per REQ-013 on that cycle's state_in; 10/11 starts a fresh spin with counter 0.
REQ-017 SHALL keep a free-running PWM counter 0..PWM_PERIOD-1, wrapping to 0, never paused by mode changes.
REQ-018 SHALL drive pwm_x = 1 iff pwm counter < duty_x; duty == 0 gives constant 0, duty == PWM_PERIOD gives constant 1.
REQ-019 SHALL in STOP: duty_left = duty_right = 0, both dir = 1.
REQ-020 SHALL in DRIVE: both dir = 1, shared duty cleared to 0 on DRIVE entry, incremented by RAMP_STEP on each cycle where pwm counter == PWM_PERIOD-1, saturating at PWM_PERIOD.
REQ-021 SHALL in SPIN_L: dir_left = 0, dir_right = 1; in SPIN_R: dir_left = 1, dir_right = 0; both duties = TURN_DUTY.
REQ-022 SHALL assert busy exactly while mode is SPIN_L or SPIN_R.
REQ-023 SHALL have no combinational path from state_in to any output; outputs reflect the mode register one cycle after the sampling edge.
REQ-024 SHALL size counters to hold their maximum without overflow (PWM/duty 8 bits, turn 16 bits).

Reset
REQ-025 SHALL, while reset is high, force mode STOP, pwm counter 0, duty 0, turn counter 0.
REQ-026 SHALL hold outputs at pwm_left = pwm_right = 0, dir_left = dir_right = 1, busy = 0, turn_done = 0 during and after reset until a non-00 state_in is sampled.
REQ-027 SHALL abandon a spin or ramp in progress on reset without a turn_done pulse.

Structure
REQ-028 SHALL take the state_in code type (IDLE, MOVE_FORWARD, TURN_LEFT, TURN_RIGHT) from shared package robot_pkg, alongside the upstream navigation FSM, and define the drive mode enum there.
REQ-029 SHALL implement each compare stage (counter < duty) as two instances of sub-module pwm_channel, sharing the single PWM counter.

Verification
REQ-030 SHALL check reset: reset high 3 cycles -> all pwm 0, dir 1, busy 0, turn_done 0.
REQ-031 SHALL check ramp: state_in 01 held -> duty 0,4,8,12,16 in successive frames; after 4 frame wraps pwm_left/right constantly 1.
REQ-032 SHALL check a spin: state_in 11 one cycle then 01 -> busy high exactly 32 cycles, dir_right 0, pwm high 8 of every 16 cycles, one turn_done pulse, then DRIVE ramp from duty 0.
REQ-033 SHALL check abort: state_in 10 then 00 at spin cycle 10 -> mode STOP next cycle, busy low, no turn_done pulse.
REQ-034 SHALL check back-to-back: state_in 10 on the completion cycle of a SPIN_R -> turn_done pulses, SPIN_L starts with counter 0, busy stays high.
REQ-035 SHALL check reset mid-operation: reset asserted at DRIVE duty 12 -> next cycle pwm 0, duty 0; subsequent 01 ramps from 0.

Source files
------------

// File: rtl/robot_pkg.sv
// Shared navigation/drive types for the robot motor path.
package robot_pkg;

   localparam int PWM_W  = 8;
   localparam int TURN_W = 16;

   // Navigation state code produced by the upstream navigation FSM.
   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      MOVE_FORWARD = 2'b01,
      TURN_LEFT    = 2'b10,
      TURN_RIGHT   = 2'b11
   } nav_state_e;

   // Internal drive mode of the motor controller.
   typedef enum logic [1:0] {
      MODE_STOP   = 2'b00,
      MODE_DRIVE  = 2'b01,
      MODE_SPIN_L = 2'b10,
      MODE_SPIN_R = 2'b11
   } drive_mode_e;

   // Saturating add, clamps the result to limit.
   function automatic logic [PWM_W-1:0] sat_add(input logic [PWM_W-1:0] a,
                                                input logic [PWM_W-1:0] b,
                                                input logic [PWM_W-1:0] limit);
      logic [PWM_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, limit}) begin
         return limit;
      end else begin
         return sum[PWM_W-1:0];
      end
   endfunction

   // Drive mode requested by a navigation code when not latched in a spin.
   function automatic drive_mode_e mode_from_nav(input nav_state_e nav);
      case (nav)
         IDLE:         return MODE_STOP;
         MOVE_FORWARD: return MODE_DRIVE;
         TURN_LEFT:    return MODE_SPIN_L;
         TURN_RIGHT:   return MODE_SPIN_R;
         default:      return MODE_STOP;
      endcase
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare stage: output high while the shared counter is below duty.
// Fed with next-state counter/duty so the registered output lines up with
// the controller's mode register.
module pwm_channel
   import robot_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [PWM_W-1:0] cnt_i,
   input  logic [PWM_W-1:0] duty_i,
   output logic             pwm_o
);

   logic pwm_q;
   logic pwm_d;

   // Compare: duty 0 never fires, duty == period always fires.
   always_comb begin
      pwm_d = 1'b0;
      if (cnt_i < duty_i) begin
         pwm_d = 1'b1;
      end else begin
         pwm_d = 1'b0;
      end
   end

   // Output register, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Differential-drive motor controller: mode FSM, duty ramp, spin timer and
// two PWM channels sharing one free-running frame counter.
module motor_drive_ctrl
   import robot_pkg::*;
#(
   parameter int PWM_PERIOD  = 16,
   parameter int RAMP_STEP   = 4,
   parameter int TURN_CYCLES = 32,
   parameter int TURN_DUTY   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] state_in,
   output logic       pwm_left,
   output logic       pwm_right,
   output logic       dir_left,
   output logic       dir_right,
   output logic       busy,
   output logic       turn_done
);

   localparam logic [PWM_W-1:0]  PERIOD_C    = PWM_W'(PWM_PERIOD);
   localparam logic [PWM_W-1:0]  LAST_CNT_C  = PWM_W'(PWM_PERIOD - 1);
   localparam logic [PWM_W-1:0]  STEP_C      = PWM_W'(RAMP_STEP);
   localparam logic [PWM_W-1:0]  TURN_DUTY_C = PWM_W'(TURN_DUTY);
   localparam logic [TURN_W-1:0] TURN_LAST_C = TURN_W'(TURN_CYCLES - 1);

   nav_state_e        nav_s;
   drive_mode_e       mode_q, mode_d;
   logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic [PWM_W-1:0]  duty_q, duty_d;
   logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
   logic              turn_done_q, turn_done_d;
   logic              dir_left_q, dir_left_d;
   logic              dir_right_q, dir_right_d;
   logic              busy_q, busy_d;
   logic [PWM_W-1:0]  duty_left_s, duty_right_s;

   assign nav_s = nav_state_e'(state_in);

   // Mode FSM next state: spins are latched until completion or an IDLE abort.
   always_comb begin
      mode_d      = mode_q;
      turn_cnt_d  = turn_cnt_q;
      turn_done_d = 1'b0;
      case (mode_q)
         MODE_STOP, MODE_DRIVE: begin
            mode_d     = mode_from_nav(nav_s);
            turn_cnt_d = {TURN_W{1'b0}};
         end
         MODE_SPIN_L, MODE_SPIN_R: begin
            if (turn_cnt_q == TURN_LAST_C) begin
               // Completion: re-dispatch on this cycle's code, fresh counter.
               turn_done_d = 1'b1;
               mode_d      = mode_from_nav(nav_s);
               turn_cnt_d  = {TURN_W{1'b0}};
            end else if (nav_s == IDLE) begin
               mode_d     = MODE_STOP;
               turn_cnt_d = {TURN_W{1'b0}};
            end else begin
               turn_cnt_d = turn_cnt_q + 16'd1;
            end
         end
         default: begin
            mode_d     = MODE_STOP;
            turn_cnt_d = {TURN_W{1'b0}};
         end
      endcase
   end

   // Free-running frame counter and DRIVE duty ramp.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
      duty_d    = 8'd0;
      if (pwm_cnt_q == LAST_CNT_C) begin
         pwm_cnt_d = 8'd0;
      end else begin
         pwm_cnt_d = pwm_cnt_q + 8'd1;
      end
      if (mode_d == MODE_DRIVE) begin
         if (mode_q != MODE_DRIVE) begin
            duty_d = 8'd0;
         end else if (pwm_cnt_q == LAST_CNT_C) begin
            duty_d = sat_add(duty_q, STEP_C, PERIOD_C);
         end else begin
            duty_d = duty_q;
         end
      end else begin
         duty_d = 8'd0;
      end
   end

   // Per-mode duty, direction and busy for the upcoming cycle.
   always_comb begin
      duty_left_s  = 8'd0;
      duty_right_s = 8'd0;
      dir_left_d   = 1'b1;
      dir_right_d  = 1'b1;
      busy_d       = 1'b0;
      case (mode_d)
         MODE_STOP: begin
            duty_left_s  = 8'd0;
            duty_right_s = 8'd0;
         end
         MODE_DRIVE: begin
            duty_left_s  = duty_d;
            duty_right_s = duty_d;
         end
         MODE_SPIN_L: begin
            duty_left_s  = TURN_DUTY_C;
            duty_right_s = TURN_DUTY_C;
            dir_left_d   = 1'b0;
            busy_d       = 1'b1;
         end
         MODE_SPIN_R: begin
            duty_left_s  = TURN_DUTY_C;
            duty_right_s = TURN_DUTY_C;
            dir_right_d  = 1'b0;
            busy_d       = 1'b1;
         end
         default: begin
            duty_left_s  = 8'd0;
            duty_right_s = 8'd0;
         end
      endcase
   end

   // State and output registers; reset parks the drive in a safe STOP.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q      <= MODE_STOP;
         pwm_cnt_q   <= 8'd0;
         duty_q      <= 8'd0;
         turn_cnt_q  <= 16'd0;
         turn_done_q <= 1'b0;
         dir_left_q  <= 1'b1;
         dir_right_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         pwm_cnt_q   <= pwm_cnt_d;
         duty_q      <= duty_d;
         turn_cnt_q  <= turn_cnt_d;
         turn_done_q <= turn_done_d;
         dir_left_q  <= dir_left_d;
         dir_right_q <= dir_right_d;
         busy_q      <= busy_d;
      end
   end

   pwm_channel u_pwm_left (
      .clk    (clk),
      .reset  (reset),
      .cnt_i  (pwm_cnt_d),
      .duty_i (duty_left_s),
      .pwm_o  (pwm_left)
   );

   pwm_channel u_pwm_right (
      .clk    (clk),
      .reset  (reset),
      .cnt_i  (pwm_cnt_d),
      .duty_i (duty_right_s),
      .pwm_o  (pwm_right)
   );

   assign dir_left  = dir_left_q;
   assign dir_right = dir_right_q;
   assign busy      = busy_q;
   assign turn_done = turn_done_q;

endmodule
